// File: rtl/z_reg_sequencer.sv
// Shares the ALU and Z result register between two requesters: round-robin grant,
// then LOAD/EXEC/CAPT/PUB/DONE. Define ZSEQ_BACK_TO_BACK_EN to re-arbitrate from DONE.
module z_reg_sequencer #(
   parameter int ALU_LAT = 1,
   parameter int OPW     = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [1:0]     req,
   input  logic [OPW-1:0] op0,
   input  logic [OPW-1:0] op1,
   output logic [1:0]     grant,
   output logic [1:0]     done,
   output logic           busy,
   output logic           xy_load,
   output logic [OPW-1:0] alu_op,
   output logic [1:0]     z_ctrl
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_EXEC,
      S_CAPT,
      S_PUB,
      S_DONE
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

   state_t         state_q, state_d;
   logic           owner_q, owner_d;
   logic           last_q, last_d;
   logic [OPW-1:0] op_q, op_d;
   logic [3:0]     cnt_q, cnt_d;
   logic           arb_point;
   logic           take;
   logic           pick;
   logic [1:0]     owner_oh;

`ifdef ZSEQ_BACK_TO_BACK_EN
   assign arb_point = (state_q == S_IDLE) || (state_q == S_DONE);
`else
   assign arb_point = (state_q == S_IDLE);
`endif

   // On a tie the requester that did not win last time is chosen
   assign pick = (req == 2'b11) ? ~last_q : req[1];
   assign take = arb_point && (req != 2'b00);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (take) state_d = S_LOAD;
         S_LOAD: begin
            cnt_d   = CNT_INIT;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else               state_d = S_CAPT;
         end
         S_CAPT: state_d = S_PUB;
         S_PUB:  state_d = S_DONE;
         S_DONE: state_d = take ? S_LOAD : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (take) begin
         owner_d = pick;
         last_d  = pick;
         op_d    = pick ? op1 : op0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         op_q    <= '0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   assign owner_oh = owner_q ? 2'b10 : 2'b01;

   always_comb begin
      grant   = 2'b00;
      done    = 2'b00;
      busy    = 1'b0;
      xy_load = 1'b0;
      alu_op  = '0;
      z_ctrl  = 2'b00;
      if (state_q != S_IDLE) begin
         grant = owner_oh;
         busy  = 1'b1;
      end
      case (state_q)
         S_LOAD: begin
            xy_load = 1'b1;
            alu_op  = op_q;
         end
         S_EXEC: alu_op = op_q;
         S_CAPT: begin
            alu_op = op_q;
            z_ctrl = 2'b10;
         end
         S_PUB:  z_ctrl = 2'b01;
         S_DONE: done = owner_oh;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_z_reg_sequencer.sv
// Self-checking bench for z_reg_sequencer: directed steps, a done-order scoreboard and
// per-cycle invariants. Instance dut uses ALU_LAT=1, dut3 uses ALU_LAT=3.
module tb_z_reg_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req = 2'b00;
   logic [3:0] op0 = 4'h0;
   logic [3:0] op1 = 4'h0;
   logic [1:0] grant, done, z_ctrl;
   logic       busy, xyLoad;
   logic [3:0] aluOp;

   logic [1:0] req3 = 2'b00;
   logic [3:0] op30 = 4'h0;
   logic [3:0] op31 = 4'h0;
   logic [1:0] grant3, done3, zCtrl3;
   logic       busy3, xyLoad3;
   logic [3:0] aluOp3;

   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   logic [1:0] expDoneQ[$];
   int         doneCycles[$];
   logic [1:0] expDone;

`ifdef ZSEQ_BACK_TO_BACK_EN
   localparam int SPACING = 5;
`else
   localparam int SPACING = 6;
`endif

   z_reg_sequencer #(.ALU_LAT(1), .OPW(4)) dut (
      .clk(clk), .rst(rst), .req(req), .op0(op0), .op1(op1),
      .grant(grant), .done(done), .busy(busy), .xy_load(xyLoad),
      .alu_op(aluOp), .z_ctrl(z_ctrl)
   );

   z_reg_sequencer #(.ALU_LAT(3), .OPW(4)) dut3 (
      .clk(clk), .rst(rst), .req(req3), .op0(op30), .op1(op31),
      .grant(grant3), .done(done3), .busy(busy3), .xy_load(xyLoad3),
      .alu_op(aluOp3), .z_ctrl(zCtrl3)
   );

   // Free-running clock and cycle counter used to time done pulses
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [11:0] mk(input logic [1:0] g, input logic [1:0] d, input logic b,
                                      input logic x, input logic [3:0] o, input logic [1:0] z);
      return {g, d, b, x, o, z};
   endfunction

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] r, input logic [3:0] a, input logic [3:0] b);
      req = r;
      op0 = a;
      op1 = b;
   endtask

   task automatic applyReset();
      rst  = 1'b1;
      req  = 2'b00;
      req3 = 2'b00;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Requester model: runs until a done pulse, then that requester drops its req
   task automatic waitDone(input string tag);
      int n = 0;
      do begin
         tick();
         n++;
      end while (done == 2'b00 && n < 40);
      vectors++;
      assert (done !== 2'b00) else begin
         miscompares++;
         $error("FAIL %s_timeout: observed done=%b expected a pulse within 40 cycles", tag, done);
      end
      req = req & ~done;
   endtask

   initial begin
      // Monitor: done ordering against the scoreboard plus structural invariants
      fork
         forever begin
            @(negedge clk);
            if (done !== 2'b00) begin
               vectors++;
               if (expDoneQ.size() == 0) begin
                  miscompares++;
                  $error("FAIL unexpected_done: observed %b expected none", done);
               end else begin
                  expDone = expDoneQ.pop_front();
                  assert (done === expDone) else begin
                     miscompares++;
                     $error("FAIL done_order: observed %b expected %b", done, expDone);
                  end
               end
               doneCycles.push_back(cyc);
            end
            vectors++;
            assert (z_ctrl !== 2'b11 && zCtrl3 !== 2'b11 && $onehot0(grant) && $onehot0(done)
                    && (done & ~grant) == 2'b00 && (done3 & ~grant3) == 2'b00) else begin
               miscompares++;
               $error("FAIL invariant: observed z=%b g=%b d=%b z3=%b g3=%b d3=%b expected legal",
                      z_ctrl, grant, done, zCtrl3, grant3, done3);
            end
         end
      join_none

      // Test 1: single request, ALU_LAT=1 cycle-accurate trace
      applyReset();
      checkOutput("t1_reset", {grant, done, busy, xyLoad, aluOp, z_ctrl}, 12'h000);
      applyStimulus(2'b01, 4'h3, 4'h0);
      expDoneQ.push_back(2'b01);
      tick(); checkOutput("t1_c1_load", {grant, done, busy, xyLoad, aluOp, z_ctrl}, mk(2'b01, 2'b00, 1, 1, 4'h3, 2'b00));
      tick(); checkOutput("t1_c2_exec", {grant, done, busy, xyLoad, aluOp, z_ctrl}, mk(2'b01, 2'b00, 1, 0, 4'h3, 2'b00));
      tick(); checkOutput("t1_c3_capt", {grant, done, busy, xyLoad, aluOp, z_ctrl}, mk(2'b01, 2'b00, 1, 0, 4'h3, 2'b10));
      tick(); checkOutput("t1_c4_pub",  {grant, done, busy, xyLoad, aluOp, z_ctrl}, mk(2'b01, 2'b00, 1, 0, 4'h0, 2'b01));
      tick(); checkOutput("t1_c5_done", {grant, done, busy, xyLoad, aluOp, z_ctrl}, mk(2'b01, 2'b01, 1, 0, 4'h0, 2'b00));
      req = 2'b00;
      tick(); checkOutput("t1_c6_idle", {grant, done, busy, xyLoad, aluOp, z_ctrl}, 12'h000);

      // Test 2: simultaneous requests after reset, requester 0 wins first
      applyReset();
      applyStimulus(2'b11, 4'h5, 4'h9);
      expDoneQ.push_back(2'b01);
      expDoneQ.push_back(2'b10);
      tick(); checkOutput("t2_c1_grant0", {grant, done, busy, xyLoad, aluOp, z_ctrl}, mk(2'b01, 2'b00, 1, 1, 4'h5, 2'b00));
      waitDone("t2_first");
      waitDone("t2_second");
      req = 2'b00;

      // Test 3: both held for four ops, grants alternate, done spacing fixed
      applyReset();
      doneCycles.delete();
      applyStimulus(2'b11, 4'h1, 4'h2);
      for (int i = 0; i < 4; i++) expDoneQ.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
      for (int i = 0; i < 4; i++) begin
         waitDone("t3_op");
         req = (i < 3) ? 2'b11 : 2'b00;
      end
      tick();
      vectors++;
      assert (doneCycles.size() == 4) else begin
         miscompares++;
         $error("FAIL t3_done_count: observed %0d expected 4", doneCycles.size());
      end
      for (int k = 1; k < doneCycles.size(); k++) begin
         vectors++;
         assert (doneCycles[k] - doneCycles[k-1] == SPACING) else begin
            miscompares++;
            $error("FAIL t3_spacing: observed %0d expected %0d", doneCycles[k] - doneCycles[k-1], SPACING);
         end
      end

      // Test 4: ALU_LAT=3 instance, requester 1 alone
      applyReset();
      req3 = 2'b10;
      op30 = 4'h0;
      op31 = 4'hA;
      tick(); checkOutput("t4_c1_load", {grant3, done3, busy3, xyLoad3, aluOp3, zCtrl3}, mk(2'b10, 2'b00, 1, 1, 4'hA, 2'b00));
      for (int i = 2; i <= 4; i++) begin
         tick(); checkOutput("t4_exec", {grant3, done3, busy3, xyLoad3, aluOp3, zCtrl3}, mk(2'b10, 2'b00, 1, 0, 4'hA, 2'b00));
      end
      tick(); checkOutput("t4_c5_capt", {grant3, done3, busy3, xyLoad3, aluOp3, zCtrl3}, mk(2'b10, 2'b00, 1, 0, 4'hA, 2'b10));
      tick(); checkOutput("t4_c6_pub",  {grant3, done3, busy3, xyLoad3, aluOp3, zCtrl3}, mk(2'b10, 2'b00, 1, 0, 4'h0, 2'b01));
      tick(); checkOutput("t4_c7_done", {grant3, done3, busy3, xyLoad3, aluOp3, zCtrl3}, mk(2'b10, 2'b10, 1, 0, 4'h0, 2'b00));
      req3 = 2'b00;
      tick(); checkOutput("t4_c8_idle", {grant3, done3, busy3, xyLoad3, aluOp3, zCtrl3}, 12'h000);

      // Test 5: reset during EXEC abandons the op, then a clean restart
      applyReset();
      applyStimulus(2'b01, 4'h7, 4'h0);
      tick();
      tick();
      rst = 1'b1;
      tick(); checkOutput("t5_reset_mid", {grant, done, busy, xyLoad, aluOp, z_ctrl}, 12'h000);
      rst = 1'b0;
      expDoneQ.push_back(2'b01);
      tick(); checkOutput("t5_c1_load", {grant, done, busy, xyLoad, aluOp, z_ctrl}, mk(2'b01, 2'b00, 1, 1, 4'h7, 2'b00));
      tick();
      tick();
      tick(); checkOutput("t5_c4_pub",  {grant, done, busy, xyLoad, aluOp, z_ctrl}, mk(2'b01, 2'b00, 1, 0, 4'h0, 2'b01));
      tick(); checkOutput("t5_c5_done", {grant, done, busy, xyLoad, aluOp, z_ctrl}, mk(2'b01, 2'b01, 1, 0, 4'h0, 2'b00));
      req = 2'b00;

      // Test 6: requester drops req mid-operation, done still pulses
      applyReset();
      applyStimulus(2'b01, 4'h2, 4'h0);
      expDoneQ.push_back(2'b01);
      tick();
      tick();
      req = 2'b00;
      tick();
      tick();
      tick(); checkOutput("t6_c5_done", {grant, done, busy, xyLoad, aluOp, z_ctrl}, mk(2'b01, 2'b01, 1, 0, 4'h0, 2'b00));
      tick(); checkOutput("t6_c6_idle", {grant, done, busy, xyLoad, aluOp, z_ctrl}, 12'h000);

      tick();
      tick();
      vectors++;
      assert (expDoneQ.size() == 0) else begin
         miscompares++;
         $error("FAIL scoreboard_drain: observed %0d pending expected 0", expDoneQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
